spi_ram_burst: RTL and testbench
================================

// Module: spi_ram_burst
// PURPOSE
// Command-decoded single-port RAM behind the SPI slave: 2-bit opcode + payload per word
// on din. Successor to the fixed 8-bit RAM: parametric depth and data width, optional
// address auto-increment for burst access, and a read-return FIFO.
// Read data is handed back to the SPI slave via a valid/ready handshake, with
// back-pressure on rx. Sits between SPI slave (rx side) and SPI slave (tx side).
// PARAMETERS
// MEM_DEPTH     256  number of words (need not be a power of 2)
// ADDR_SIZE     8    address bits; MEM_DEPTH <= 2**ADDR_SIZE
// DATA_SIZE     8    memory word width
// AUTO_INC      1    1: write/read pointers post-increment on each data/read cmd
// RD_FIFO_DEPTH 4    read-return FIFO entries (>=2)
// localparam PAY_W = max(ADDR_SIZE,DATA_SIZE); CMD_W = PAY_W+2
// PORTS
// clk       in   1          clock, all logic on posedge
// rst       in   1          synchronous, active-high reset
// din       in   CMD_W      [CMD_W-1:CMD_W-2]=opcode, [PAY_W-1:0]=payload
// rx_valid  in   1          din valid
// rx_ready  out  1          block can accept a command this cycle
// dout      out  DATA_SIZE  read data at FIFO head; 0 when tx_valid=0
// tx_valid  out  1          FIFO non-empty
// tx_ready  in   1          consumer takes dout this cycle
// addr_err  out  1          1-cycle pulse: data/read cmd with pointer >= MEM_DEPTH
// BEHAVIOUR
// - Reset (rst=1 at posedge): wr_ptr=0, rd_ptr=0, FIFO empty, in-flight read cleared,
//   all memory words=0; outputs: tx_valid=0, dout=0, addr_err=0, rx_ready=1 after reset.
//   Reset mid-burst discards FIFO contents and any in-flight read.
// - Command accepted iff rx_valid && rx_ready at posedge; at most one per cycle.
// - Opcodes (payload low bits used):
//   00 wr_ptr <= payload[ADDR_SIZE-1:0]
//   01 mem[wr_ptr] <= payload[DATA_SIZE-1:0]; if AUTO_INC wr_ptr <= wr_ptr+1
//   10 rd_ptr <= payload[ADDR_SIZE-1:0]
//   11 issue read of mem[rd_ptr]; if AUTO_INC rd_ptr <= rd_ptr+1
// - Pointer increment wraps MEM_DEPTH-1 -> 0 (explicit compare, not modulo 2**ADDR_SIZE).
// - Out-of-range pointer (>= MEM_DEPTH): op 01 leaves memory unchanged; op 11 pushes 0;
//   both pulse addr_err next cycle; pointer still increments if AUTO_INC (wrap to 0).
// - Read latency: op 11 accepted at edge N -> data written into FIFO at edge N+1 ->
//   tx_valid=1 visible after N+1 if FIFO was empty (FWFT head).
// - Write at edge N then read of same address accepted at N+1 returns new data.
// - rx_ready = (fifo_count + inflight) < RD_FIFO_DEPTH; deasserts for all opcodes,
//   so command order is preserved. A read can never be dropped.
// - FIFO pop on tx_valid && tx_ready. Push and pop in same cycle: count unchanged,
//   head advances. tx_valid/dout held stable while tx_ready=0.
// - Non-read commands never affect tx_valid/dout.
// TESTING
// 1 rst; 00/0x10, 01/0xA5, 10/0x10, 11 -> tx_valid 1 two edges after 11 accept, dout=0xA5
// 2 AUTO_INC=1: 00/0xFE, 01/0x11, 01/0x22, 01/0x33; 10/0xFE, 11 x3 -> dout 0x11,0x22,0x33
//   (third from addr 0, wrap)
// 3 MEM_DEPTH=200: 10/0xC8, 11 -> dout=0, addr_err pulse; 00/0xC7,01,01 -> 2nd write at 0
// 4 tx_ready=0, issue 6 reads (DEPTH=4) -> rx_ready low after 4th; tx_ready=1 -> all 6
//   returned in order, none lost
// 5 simultaneous push/pop with tx_ready=1 continuous burst of 16 reads -> 1 word/cycle
// 6 rst asserted with 3 words queued + read in flight -> next cycle tx_valid=0, dout=0,
//   rx_ready=1, memory reads back 0

Source files
------------

// File: rtl/spi_ram_burst.sv
// Purpose : command-decoded burst RAM behind an SPI slave; 2-bit opcode + payload per word,
//           optional pointer auto-increment, read data returned through an FWFT FIFO.
// Latency : read command accepted at edge N -> word enters FIFO at edge N+1 (tx_valid after N+1).
// Backpr. : rx_ready drops whenever queued + in-flight reads would fill the FIFO, for every opcode.
// Ports   : clk, rst (sync, active-high); din/rx_valid/rx_ready command side;
//           dout/tx_valid/tx_ready read-return side; addr_err 1-cycle out-of-range pulse.

// Generic first-word-fall-through FIFO, any depth >= 1.
// Ports: push_vld/push_dat write side, pop_vld/pop_dat/pop_rdy read side, count occupancy.
module spi_ram_burst_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push_vld,
  input  logic [W-1:0]                 push_dat,
  output logic                         pop_vld,
  output logic [W-1:0]                 pop_dat,
  input  logic                         pop_rdy,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  buf_q [DEPTH];
  logic [IW-1:0] head_q, head_d;
  logic [IW-1:0] tail_q, tail_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign pop_vld = (cnt_q != '0);
  // Idle output is forced to zero so the consumer never sees stale data.
  assign pop_dat = pop_vld ? buf_q[head_q] : '0;
  assign count   = cnt_q;
  assign do_pop  = pop_vld && pop_rdy;
  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign do_push = push_vld && ((cnt_q != CW'(DEPTH)) || do_pop);

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    if (do_pop)  head_d = (head_q == IW'(DEPTH - 1)) ? '0 : head_q + IW'(1);
    if (do_push) tail_d = (tail_q == IW'(DEPTH - 1)) ? '0 : tail_q + IW'(1);
    if (do_push && !do_pop) cnt_d = cnt_q + CW'(1);
    if (do_pop && !do_push) cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
      if (do_push) buf_q[tail_q] <= push_dat;
    end
  end
endmodule

module spi_ram_burst #(
  parameter  int MEM_DEPTH     = 256,
  parameter  int ADDR_SIZE     = 8,
  parameter  int DATA_SIZE     = 8,
  parameter  int AUTO_INC      = 1,
  parameter  int RD_FIFO_DEPTH = 4,
  localparam int PAY_W         = (ADDR_SIZE > DATA_SIZE) ? ADDR_SIZE : DATA_SIZE,
  localparam int CMD_W         = PAY_W + 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [CMD_W-1:0]     din,
  input  logic                 rx_valid,
  output logic                 rx_ready,
  output logic [DATA_SIZE-1:0] dout,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic                 addr_err
);
  localparam int FCW = $clog2(RD_FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    OP_SET_WP = 2'b00,
    OP_WRITE  = 2'b01,
    OP_SET_RP = 2'b10,
    OP_READ   = 2'b11
  } op_e;

  logic [DATA_SIZE-1:0] mem_q [MEM_DEPTH];
  logic [ADDR_SIZE-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_SIZE-1:0] rd_ptr_q, rd_ptr_d;
  logic                 inflight_q, inflight_d;
  logic [DATA_SIZE-1:0] rd_dat_q, rd_dat_d;
  logic                 addr_err_q, addr_err_d;
  logic                 mem_we;
  logic                 accept;
  logic                 wr_in_range, rd_in_range;
  op_e                  op;
  logic [PAY_W-1:0]     pay;
  logic [FCW-1:0]       fifo_cnt;

  // Pointers wrap at MEM_DEPTH, not at 2**ADDR_SIZE; an out-of-range pointer also lands on 0.
  function automatic logic [ADDR_SIZE-1:0] ptr_inc(input logic [ADDR_SIZE-1:0] p);
    ptr_inc = (int'(p) >= MEM_DEPTH - 1) ? '0 : p + ADDR_SIZE'(1);
  endfunction

  assign op          = op_e'(din[CMD_W-1:CMD_W-2]);
  assign pay         = din[PAY_W-1:0];
  assign accept      = rx_valid && rx_ready;
  assign wr_in_range = int'(wr_ptr_q) < MEM_DEPTH;
  assign rd_in_range = int'(rd_ptr_q) < MEM_DEPTH;

  // Reserve a FIFO slot for the read still in flight so a read can never be dropped.
  // Stalling every opcode (not just reads) keeps command order intact.
  assign rx_ready = (int'(fifo_cnt) + int'(inflight_q)) < RD_FIFO_DEPTH;
  assign addr_err = addr_err_q;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    inflight_d = 1'b0;
    rd_dat_d   = rd_dat_q;
    addr_err_d = 1'b0;
    mem_we     = 1'b0;
    if (accept) begin
      case (op)
        OP_SET_WP: wr_ptr_d = pay[ADDR_SIZE-1:0];
        OP_WRITE: begin
          mem_we     = wr_in_range;
          addr_err_d = !wr_in_range;
          if (AUTO_INC != 0) wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        OP_SET_RP: rd_ptr_d = pay[ADDR_SIZE-1:0];
        OP_READ: begin
          // The memory is read at the accepting edge, so a write one edge earlier is visible.
          inflight_d = 1'b1;
          rd_dat_d   = rd_in_range ? mem_q[rd_ptr_q] : '0;
          addr_err_d = !rd_in_range;
          if (AUTO_INC != 0) rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      inflight_q <= 1'b0;
      rd_dat_q   <= '0;
      addr_err_q <= 1'b0;
      for (int i = 0; i < MEM_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      inflight_q <= inflight_d;
      rd_dat_q   <= rd_dat_d;
      addr_err_q <= addr_err_d;
      if (mem_we) mem_q[wr_ptr_q] <= pay[DATA_SIZE-1:0];
    end
  end

  spi_ram_burst_fifo #(
    .DEPTH (RD_FIFO_DEPTH),
    .W     (DATA_SIZE)
  ) u_rd_fifo (
    .clk      (clk),
    .rst      (rst),
    .push_vld (inflight_q),
    .push_dat (rd_dat_q),
    .pop_vld  (tx_valid),
    .pop_dat  (dout),
    .pop_rdy  (tx_ready),
    .count    (fifo_cnt)
  );
endmodule

// File: tb/tb_spi_ram_burst.sv
// Bench for spi_ram_burst: two instances (depth 256 and depth 200) share stimulus,
// a queue-based reference model predicts every returned read word and addr_err pulse.
module tb_spi_ram_burst;
  localparam int CMD_W = 10;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [CMD_W-1:0] din = '0;
  logic             rx_valid = 1'b0;
  logic             tx_ready = 1'b0;
  logic             sel = 1'b0;

  logic       rx_ready_a, tx_valid_a, addr_err_a;
  logic       rx_ready_b, tx_valid_b, addr_err_b;
  logic [7:0] dout_a, dout_b;
  logic       rx_ready_s, tx_valid_s, addr_err_s;
  logic [7:0] dout_s;

  always #5 clk = ~clk;

  spi_ram_burst dut_a (
    .clk(clk), .rst(rst), .din(din), .rx_valid(rx_valid && !sel), .rx_ready(rx_ready_a),
    .dout(dout_a), .tx_valid(tx_valid_a), .tx_ready(tx_ready), .addr_err(addr_err_a)
  );

  spi_ram_burst #(.MEM_DEPTH(200)) dut_b (
    .clk(clk), .rst(rst), .din(din), .rx_valid(rx_valid && sel), .rx_ready(rx_ready_b),
    .dout(dout_b), .tx_valid(tx_valid_b), .tx_ready(tx_ready), .addr_err(addr_err_b)
  );

  assign rx_ready_s = sel ? rx_ready_b : rx_ready_a;
  assign tx_valid_s = sel ? tx_valid_b : tx_valid_a;
  assign addr_err_s = sel ? addr_err_b : addr_err_a;
  assign dout_s     = sel ? dout_b     : dout_a;

  // Reference model state
  int         m_depth = 256;
  logic [7:0] m_mem [256];
  int         m_wp, m_rp;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int         pop_cyc_q[$];
  int         exp_err, err_cnt, cyc;
  int         test_cnt = 0;
  int         fail_cnt = 0;

  // Collector: records every word handed over and every addr_err cycle.
  always @(negedge clk) begin
    cyc++;
    if (!rst && tx_valid_s && tx_ready) begin
      got_q.push_back(dout_s);
      pop_cyc_q.push_back(cyc);
    end
    if (!rst && addr_err_s) err_cnt++;
  end

  function automatic void model_reset();
    for (int i = 0; i < 256; i++) m_mem[i] = 8'h00;
    m_wp = 0; m_rp = 0;
    exp_q.delete(); got_q.delete(); pop_cyc_q.delete();
    exp_err = 0; err_cnt = 0;
    m_depth = sel ? 200 : 256;
  endfunction

  function automatic int next_ptr(input int p);
    return (p + 1 >= m_depth) ? 0 : p + 1;
  endfunction

  function automatic void model_cmd(input logic [1:0] op, input logic [7:0] pay);
    case (op)
      2'd0: m_wp = int'(pay);
      2'd1: begin
        if (m_wp < m_depth) m_mem[m_wp] = pay;
        else exp_err++;
        m_wp = next_ptr(m_wp);
      end
      2'd2: m_rp = int'(pay);
      default: begin
        if (m_rp < m_depth) exp_q.push_back(m_mem[m_rp]);
        else begin exp_q.push_back(8'h00); exp_err++; end
        m_rp = next_ptr(m_rp);
      end
    endcase
  endfunction

  task automatic do_reset();
    rst = 1'b1; rx_valid = 1'b0; tx_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask

  // Presents one command and holds it until accepted; returns 1 ns after the accepting edge.
  task automatic send_cmd(input logic [1:0] op, input logic [7:0] pay, output bit waited);
    int n = 0;
    waited = 1'b0;
    din = {op, pay};
    rx_valid = 1'b1;
    @(negedge clk);
    while (!rx_ready_s && n < 100) begin
      waited = 1'b1; n++;
      @(negedge clk);
    end
    if (!rx_ready_s) begin
      test_cnt++; fail_cnt++;
      $display("FAIL cmd_accept_timeout: rx_ready=%0b after %0d cycles, required 1", rx_ready_s, n);
      rx_valid = 1'b0;
    end else begin
      model_cmd(op, pay);
      @(posedge clk);
      #1 rx_valid = 1'b0;
    end
  endtask

  task automatic cmd(input logic [1:0] op, input logic [7:0] pay);
    bit w;
    send_cmd(op, pay, w);
  endtask

  task automatic wait_drain(output bit ok);
    int n = 0;
    tx_ready = 1'b1;
    while (got_q.size() < exp_q.size() && n < 500) begin
      @(posedge clk); #1 n++;
    end
    repeat (3) @(posedge clk);
    #1 ok = (got_q.size() >= exp_q.size());
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    test_cnt++; if (tx_valid_s !== 1'b0) begin fail_cnt++; $display("FAIL reset_tx_valid: got %0b required 0", tx_valid_s); end
    test_cnt++; if (dout_s !== 8'h00) begin fail_cnt++; $display("FAIL reset_dout: got %h required 00", dout_s); end
    test_cnt++; if (addr_err_s !== 1'b0) begin fail_cnt++; $display("FAIL reset_addr_err: got %0b required 0", addr_err_s); end
    test_cnt++; if (rx_ready_s !== 1'b1) begin fail_cnt++; $display("FAIL reset_rx_ready: got %0b required 1", rx_ready_s); end
  endtask

  task automatic test_basic();
    bit ok;
    do_reset();
    cmd(2'd0, 8'h10); cmd(2'd1, 8'hA5); cmd(2'd2, 8'h10);
    cmd(2'd3, 8'h00);
    @(negedge clk);
    test_cnt++; if (tx_valid_s !== 1'b0) begin fail_cnt++; $display("FAIL basic_early_valid: got %0b required 0", tx_valid_s); end
    @(negedge clk);
    test_cnt++; if (tx_valid_s !== 1'b1) begin fail_cnt++; $display("FAIL basic_latency: tx_valid %0b required 1", tx_valid_s); end
    test_cnt++; if (dout_s !== exp_q[0]) begin fail_cnt++; $display("FAIL basic_dout: got %h required %h", dout_s, exp_q[0]); end
    repeat (3) @(negedge clk);
    test_cnt++; if (tx_valid_s !== 1'b1 || dout_s !== exp_q[0]) begin
      fail_cnt++; $display("FAIL basic_hold: valid %0b dout %h required 1 %h", tx_valid_s, dout_s, exp_q[0]);
    end
    wait_drain(ok);
    test_cnt++; if (!ok || got_q.size() != exp_q.size()) begin
      fail_cnt++; $display("FAIL basic_count: got %0d words required %0d", got_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      test_cnt++; if (got_q[i] !== exp_q[i]) begin fail_cnt++; $display("FAIL basic_word%0d: got %h required %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_burst_wrap();
    bit ok;
    do_reset();
    tx_ready = 1'b1;
    cmd(2'd0, 8'hFE); cmd(2'd1, 8'h11); cmd(2'd1, 8'h22); cmd(2'd1, 8'h33);
    cmd(2'd2, 8'hFE);
    repeat (3) cmd(2'd3, 8'h00);
    wait_drain(ok);
    test_cnt++; if (!ok || got_q.size() != exp_q.size()) begin
      fail_cnt++; $display("FAIL wrap_count: got %0d words required %0d", got_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      test_cnt++; if (got_q[i] !== exp_q[i]) begin fail_cnt++; $display("FAIL wrap_word%0d: got %h required %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_out_of_range();
    bit ok;
    sel = 1'b1;
    do_reset();
    cmd(2'd2, 8'hC8);
    cmd(2'd3, 8'h00);
    @(negedge clk);
    test_cnt++; if (addr_err_s !== 1'b1) begin fail_cnt++; $display("FAIL oor_err_pulse: got %0b required 1", addr_err_s); end
    @(negedge clk);
    test_cnt++; if (addr_err_s !== 1'b0) begin fail_cnt++; $display("FAIL oor_err_width: got %0b required 0", addr_err_s); end
    cmd(2'd0, 8'hC7); cmd(2'd1, 8'h5A); cmd(2'd1, 8'h6B);
    cmd(2'd2, 8'h00); cmd(2'd3, 8'h00);
    cmd(2'd2, 8'hC7); cmd(2'd3, 8'h00);
    wait_drain(ok);
    test_cnt++; if (!ok || got_q.size() != exp_q.size()) begin
      fail_cnt++; $display("FAIL oor_count: got %0d words required %0d", got_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      test_cnt++; if (got_q[i] !== exp_q[i]) begin fail_cnt++; $display("FAIL oor_word%0d: got %h required %h", i, got_q[i], exp_q[i]); end
    end
    test_cnt++; if (err_cnt != exp_err) begin fail_cnt++; $display("FAIL oor_err_count: got %0d required %0d", err_cnt, exp_err); end
    sel = 1'b0;
    do_reset();
  endtask

  task automatic test_backpressure();
    bit ok;
    do_reset();
    cmd(2'd0, 8'h00);
    for (int i = 0; i < 6; i++) cmd(2'd1, 8'($urandom));
    cmd(2'd2, 8'h00);
    tx_ready = 1'b0;
    repeat (4) cmd(2'd3, 8'h00);
    @(negedge clk);
    test_cnt++; if (rx_ready_s !== 1'b0) begin fail_cnt++; $display("FAIL bp_rx_ready_low: got %0b required 0", rx_ready_s); end
    repeat (2) @(negedge clk);
    test_cnt++; if (rx_ready_s !== 1'b0 || tx_valid_s !== 1'b1 || dout_s !== exp_q[0]) begin
      fail_cnt++; $display("FAIL bp_hold: rx_ready %0b valid %0b dout %h required 0 1 %h", rx_ready_s, tx_valid_s, dout_s, exp_q[0]);
    end
    fork
      begin cmd(2'd3, 8'h00); cmd(2'd3, 8'h00); end
      begin repeat (3) @(posedge clk); #1 tx_ready = 1'b1; end
    join
    wait_drain(ok);
    test_cnt++; if (!ok || got_q.size() != 6 || exp_q.size() != 6) begin
      fail_cnt++; $display("FAIL bp_count: got %0d words required 6", got_q.size());
    end else foreach (exp_q[i]) begin
      test_cnt++; if (got_q[i] !== exp_q[i]) begin fail_cnt++; $display("FAIL bp_word%0d: got %h required %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_back_to_back();
    bit ok, w;
    int stalls = 0;
    do_reset();
    cmd(2'd0, 8'h00);
    for (int i = 0; i < 16; i++) cmd(2'd1, 8'($urandom));
    cmd(2'd2, 8'h00);
    tx_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      send_cmd(2'd3, 8'h00, w);
      if (w) stalls++;
    end
    test_cnt++; if (stalls != 0) begin fail_cnt++; $display("FAIL b2b_stalls: got %0d stalled reads required 0", stalls); end
    wait_drain(ok);
    test_cnt++; if (!ok || got_q.size() != 16) begin
      fail_cnt++; $display("FAIL b2b_count: got %0d words required 16", got_q.size());
    end else begin
      test_cnt++; if (pop_cyc_q[15] - pop_cyc_q[0] != 15) begin
        fail_cnt++; $display("FAIL b2b_rate: 16 words spanned %0d cycles required 15", pop_cyc_q[15] - pop_cyc_q[0]);
      end
      foreach (exp_q[i]) begin
        test_cnt++; if (got_q[i] !== exp_q[i]) begin fail_cnt++; $display("FAIL b2b_word%0d: got %h required %h", i, got_q[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    do_reset();
    cmd(2'd0, 8'h00);
    for (int i = 0; i < 4; i++) cmd(2'd1, 8'($urandom) | 8'h01);
    cmd(2'd2, 8'h00);
    tx_ready = 1'b0;
    repeat (4) cmd(2'd3, 8'h00);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    test_cnt++; if (tx_valid_s !== 1'b0) begin fail_cnt++; $display("FAIL midrst_tx_valid: got %0b required 0", tx_valid_s); end
    test_cnt++; if (dout_s !== 8'h00) begin fail_cnt++; $display("FAIL midrst_dout: got %h required 00", dout_s); end
    test_cnt++; if (rx_ready_s !== 1'b1) begin fail_cnt++; $display("FAIL midrst_rx_ready: got %0b required 1", rx_ready_s); end
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    @(negedge clk);
    test_cnt++; if (tx_valid_s !== 1'b0) begin fail_cnt++; $display("FAIL midrst_no_leak: tx_valid %0b required 0", tx_valid_s); end
    cmd(2'd2, 8'h00);
    repeat (4) cmd(2'd3, 8'h00);
    wait_drain(ok);
    test_cnt++; if (!ok || got_q.size() != exp_q.size()) begin
      fail_cnt++; $display("FAIL midrst_count: got %0d words required %0d", got_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      test_cnt++; if (got_q[i] !== exp_q[i]) begin fail_cnt++; $display("FAIL midrst_word%0d: got %h required %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_random();
    bit ok;
    bit done = 1'b0;
    do_reset();
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          logic [1:0] op;
          logic [7:0] pay;
          op = 2'($urandom_range(0, 3));
          pay = (op == 2'd0 || op == 2'd2) ? 8'($urandom_range(0, 15)) : 8'($urandom);
          cmd(op, pay);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(negedge clk);
          if (!tx_valid_s) begin
            test_cnt++; if (dout_s !== 8'h00) begin fail_cnt++; $display("FAIL rand_idle_dout: got %h required 00", dout_s); end
          end
          @(posedge clk);
          #1 tx_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    wait_drain(ok);
    test_cnt++; if (!ok || got_q.size() != exp_q.size()) begin
      fail_cnt++; $display("FAIL rand_count: got %0d words required %0d", got_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      test_cnt++; if (got_q[i] !== exp_q[i]) begin fail_cnt++; $display("FAIL rand_word%0d: got %h required %h", i, got_q[i], exp_q[i]); end
    end
    test_cnt++; if (err_cnt != exp_err) begin fail_cnt++; $display("FAIL rand_err_count: got %0d required %0d", err_cnt, exp_err); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_burst_wrap();
    test_out_of_range();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, %0d failures so far", fail_cnt);
    $fatal(1, "watchdog expired");
  end
endmodule
